// File: rtl/conv_window_gen_rgb888.sv
// conv_window_gen_rgb888: turns a row-major RGB888 raster into 3x3 interior windows
// using two line buffers, for the 3x3 convolution stage.
module conv_window_gen_rgb888 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 24,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             i_sof,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_pixel,
  output logic [PIX_W-1:0] o_p1,
  output logic [PIX_W-1:0] o_p2,
  output logic [PIX_W-1:0] o_p3,
  output logic [PIX_W-1:0] o_p4,
  output logic [PIX_W-1:0] o_p5,
  output logic [PIX_W-1:0] o_p6,
  output logic [PIX_W-1:0] o_p7,
  output logic [PIX_W-1:0] o_p8,
  output logic [PIX_W-1:0] o_p9,
  output logic             o_win_valid,
  output logic [CW-1:0]    o_cx,
  output logic [RW-1:0]    o_cy,
  output logic             o_frame_done
);
  localparam logic [CW-1:0] XMAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] YMAX = RW'(IMG_H - 1);
  logic [CW-1:0]    col_q, col_d, col_x, cx_q;
  logic [RW-1:0]    row_q, row_d, row_y, cy_q;
  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] p_q [9];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic             last_x, last_y, win_d, win_q, fd_q;
  // i_sof forces the current pixel to (0,0) regardless of where the counters are
  always_comb begin
    col_x  = i_sof ? '0 : col_q;
    row_y  = i_sof ? '0 : row_q;
    last_x = col_x == XMAX;
    last_y = row_y == YMAX;
    col_d  = last_x ? '0 : col_x + CW'(1);
    row_d  = last_x ? (last_y ? '0 : row_y + RW'(1)) : row_y;
    lb0_rd = lb0_q[col_x];
    lb1_rd = lb1_q[col_x];
    win_d  = i_valid && col_x >= CW'(2) && row_y >= RW'(2);
  end
  // Line RAM is left uninitialised; lines 0 and 1 are rewritten before any window uses them
  always_ff @(posedge iClk)
    if (i_valid) begin
      lb0_q[col_x] <= lb1_rd;
      lb1_q[col_x] <= i_pixel;
    end
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      col_q <= '0;
      row_q <= '0;
      p_q   <= '{default: '0};
      win_q <= 1'b0;
      fd_q  <= 1'b0;
      cx_q  <= '0;
      cy_q  <= '0;
    end else begin
      win_q <= win_d;
      fd_q  <= win_d && last_x && last_y;
      if (i_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        p_q   <= '{p_q[1], p_q[2], lb0_rd, p_q[4], p_q[5], lb1_rd, p_q[7], p_q[8], i_pixel};
      end
      if (win_d) begin
        cx_q <= col_x - CW'(1);
        cy_q <= row_y - RW'(1);
      end
    end
  assign o_p1         = p_q[0];
  assign o_p2         = p_q[1];
  assign o_p3         = p_q[2];
  assign o_p4         = p_q[3];
  assign o_p5         = p_q[4];
  assign o_p6         = p_q[5];
  assign o_p7         = p_q[6];
  assign o_p8         = p_q[7];
  assign o_p9         = p_q[8];
  assign o_win_valid  = win_q;
  assign o_cx         = cx_q;
  assign o_cy         = cy_q;
  assign o_frame_done = fd_q;
endmodule

// File: tb/tb_conv_window_gen_rgb888.sv
// tb_conv_window_gen_rgb888: scoreboard bench; a 4x4 instance against an image-array
// model, plus a 16x8 instance for whole-frame window and frame-done counts.
module tb_conv_window_gen_rgb888;
  localparam int W = 4, H = 4;
  typedef struct packed {
    logic [8:0][23:0] p;
    logic [7:0]       cx, cy;
    logic             fd;
  } win_t;
  logic        iClk = 1'b0, iRst_n = 1'b0, i_sof = 1'b0, i_valid = 1'b0;
  logic [23:0] i_pixel = '0;
  logic [23:0] po [9];
  logic        wv, fd;
  logic [1:0]  cx, cy;
  logic        b_valid = 1'b0;
  logic [23:0] b_pixel = '0;
  logic [23:0] bp [9];
  logic        b_wv, b_fd;
  logic [3:0]  b_cx;
  logic [2:0]  b_cy;
  win_t        sbq [$];
  logic [23:0] img [H][W];
  int          mx = 0, my = 0, n_chk = 0, n_err = 0, n_win = 0, n_fd = 0;
  int          n2_win = 0, n2_fd = 0, fd2_cx = 0, fd2_cy = 0;
  logic        exp_wv = 1'b0, mon_en = 1'b0;

  conv_window_gen_rgb888 #(.IMG_W(W), .IMG_H(H), .PIX_W(24)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .i_sof(i_sof), .i_valid(i_valid), .i_pixel(i_pixel),
    .o_p1(po[0]), .o_p2(po[1]), .o_p3(po[2]), .o_p4(po[3]), .o_p5(po[4]),
    .o_p6(po[5]), .o_p7(po[6]), .o_p8(po[7]), .o_p9(po[8]),
    .o_win_valid(wv), .o_cx(cx), .o_cy(cy), .o_frame_done(fd));

  conv_window_gen_rgb888 #(.IMG_W(16), .IMG_H(8), .PIX_W(24)) dut_b (
    .iClk(iClk), .iRst_n(iRst_n), .i_sof(1'b0), .i_valid(b_valid), .i_pixel(b_pixel),
    .o_p1(bp[0]), .o_p2(bp[1]), .o_p3(bp[2]), .o_p4(bp[3]), .o_p5(bp[4]),
    .o_p6(bp[5]), .o_p7(bp[6]), .o_p8(bp[7]), .o_p9(bp[8]),
    .o_win_valid(b_wv), .o_cx(b_cx), .o_cy(b_cy), .o_frame_done(b_fd));

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix(input int f, input int x, input int y);
    return {8'(y + 16 * f), 8'(x + 16 * f), (f == 0) ? 8'hAA : 8'h55};
  endfunction

  task automatic send(input logic sof, input logic [23:0] d);
    win_t w;
    bit   hit;
    w = '0;
    i_valid = 1'b1;
    i_sof   = sof;
    i_pixel = d;
    if (sof) begin mx = 0; my = 0; end
    img[my][mx] = d;
    hit = mx >= 2 && my >= 2;
    if (hit) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) w.p[r * 3 + c] = img[my - 2 + r][mx - 2 + c];
      w.cx = 8'(mx - 1);
      w.cy = 8'(my - 1);
      w.fd = mx == W - 1 && my == H - 1;
    end
    if (mx == W - 1) begin mx = 0; my = (my == H - 1) ? 0 : my + 1; end
    else mx++;
    @(posedge iClk); #1;
    exp_wv = hit;
    if (hit) sbq.push_back(w);
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin @(posedge iClk); #1; exp_wv = 1'b0; end
  endtask

  task automatic frame(input int f, input logic sof, input bit gap);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (gap) while ($urandom_range(1) == 1) idle(1);
        send(sof && x == 0 && y == 0, pix(f, x, y));
      end
  endtask

  task automatic phase_end(input string tag, input int wins, input int fds);
    idle(2);
    chk({tag, "_nwin"}, 32'(n_win), 32'(wins));
    chk({tag, "_nfd"}, 32'(n_fd), 32'(fds));
    chk({tag, "_sb_left"}, 32'(sbq.size()), 0);
    sbq.delete();
    n_win = 0;
    n_fd  = 0;
  endtask

  task automatic zero_chk(input string tag);
    logic [23:0] acc;
    acc = '0;
    for (int i = 0; i < 9; i++) acc |= po[i];
    chk({tag, "_wv"}, 32'(wv), 0);
    chk({tag, "_fd"}, 32'(fd), 0);
    chk({tag, "_cx"}, 32'(cx), 0);
    chk({tag, "_cy"}, 32'(cy), 0);
    chk({tag, "_pix"}, 32'(acc), 0);
  endtask

  always @(negedge iClk)
    if (mon_en) begin
      chk("win_valid", 32'(wv), 32'(exp_wv));
      if (wv) begin
        n_win++;
        if (fd) n_fd++;
        chk("sb_nonempty", 32'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          win_t w;
          w = sbq.pop_front();
          for (int i = 0; i < 9; i++) chk($sformatf("p%0d", i + 1), 32'(po[i]), 32'(w.p[i]));
          chk("cx", 32'(cx), 32'(w.cx));
          chk("cy", 32'(cy), 32'(w.cy));
          chk("frame_done", 32'(fd), 32'(w.fd));
        end
      end else chk("fd_idle", 32'(fd), 0);
    end

  always @(negedge iClk) begin
    if (b_wv) n2_win++;
    if (b_fd) begin n2_fd++; fd2_cx = int'(b_cx); fd2_cy = int'(b_cy); end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge iClk);
    #1 zero_chk("reset");
    iRst_n = 1'b1;
    idle(1);
    mon_en = 1'b1;
    frame(0, 1'b0, 1'b0);
    phase_end("basic", 4, 1);
    frame(0, 1'b0, 1'b1);
    frame(1, 1'b1, 1'b0);
    phase_end("gap_2frm", 8, 2);
    for (int k = 0; k < 6; k++) send(1'b0, pix(0, k % W, k / W));
    frame(2, 1'b1, 1'b0);
    phase_end("resync", 4, 1);
    for (int k = 0; k < 5; k++) send(1'b0, pix(2, k % W, k / W));
    #2 iRst_n = 1'b0;
    #1 zero_chk("midrst");
    mx = 0;
    my = 0;
    exp_wv = 1'b0;
    idle(2);
    #2 iRst_n = 1'b1;
    idle(1);
    frame(3, 1'b0, 1'b0);
    phase_end("after_rst", 4, 1);
    mon_en = 1'b0;
    for (int k = 0; k < 16 * 8; k++) begin
      b_valid = 1'b1;
      b_pixel = 24'(k);
      @(posedge iClk); #1;
    end
    b_valid = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    chk("big_nwin", 32'(n2_win), 32'(14 * 6));
    chk("big_nfd", 32'(n2_fd), 1);
    chk("big_fd_cx", 32'(fd2_cx), 14);
    chk("big_fd_cy", 32'(fd2_cy), 6);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/conv_window_gen_rgb888.md
Name: conv_window_gen_rgb888

Overview:
Raster-to-window producer for the 3x3 RGB888 convolution stage. It accepts a row-major 24-bit pixel stream, buffers the two previous image lines and emits a 3x3 window (p1..p9) plus a window-valid strobe. These outputs drive the convolution block's i_p1..i_p9 and i_enable inputs directly. Only interior windows are emitted; the block applies no padding.

Parameters:
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)
PIX_W, 24, pixel width, packed {R[23:16],G[15:8],B[7:0]}

Ports:
iClk  in  1  clock
iRst_n  in  1  reset; asynchronous, active-low
i_sof  in  1  start of frame, qualified by i_valid; marks the pixel at (0,0)
i_valid  in  1  input pixel valid; the block applies no backpressure and always accepts
i_pixel  in  PIX_W  input pixel
o_p1..o_p9  out  PIX_W each  window: p1..p3 = line y-2, p4..p6 = line y-1, p7..p9 = line y; left to right = columns x-2, x-1, x
o_win_valid  out  1  window valid; connects to the convolution i_enable
o_cx  out  clog2(IMG_W)  window centre column (x-1)
o_cy  out  clog2(IMG_H)  window centre line (y-1)
o_frame_done  out  1  one-cycle pulse that coincides with the last window of a frame

Behaviour:
- Reset: all outputs are 0. Column counter col = 0, line counter row = 0, window shift registers = 0. Line-buffer RAM contents are not cleared.
- Accepted pixel: a pixel is accepted when i_valid = 1. When i_valid = 0, no state advances and all outputs hold their values, except o_win_valid and o_frame_done, which go to 0.
- Counters:
  - On accept, col increments.
  - At col = IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_W-1, IMG_H-1), both counters wrap to 0.
- i_sof: if i_valid & i_sof, the pixel is treated as (0,0) whatever the counter values, and the counters continue from (1,0). This resynchronises a mis-aligned stream. i_sof without i_valid is ignored.
- Line buffers: two IMG_W-deep buffers, LB1 holding line y-1 and LB0 holding line y-2, addressed by col, read-before-write. On accept:
  - LB1[col] is read as the line y-1 sample.
  - LB0[col] is read as the line y-2 sample.
  - LB0[col] is written with the old LB1[col].
  - LB1[col] is written with i_pixel.
- Window shift: on accept, each window row shifts left by one.
  - p1 <- p2 <- p3 <- LB0 read.
  - p4 <- p5 <- p6 <- LB1 read.
  - p7 <- p8 <- p9 <- i_pixel.
- Window valid:
  - o_win_valid is registered: 1 in the cycle after accepting the pixel at (x,y) with x >= 2 and y >= 2, otherwise 0.
  - Latency is 1 clock from the accepted pixel to its window.
  - Windows per frame = (IMG_W-2)*(IMG_H-2).
  - No window spans a line wrap: windows at x = 0 and x = 1 are suppressed.
- Centre coordinates: o_cx = x-1 and o_cy = y-1, registered with the window.
- Frame done: o_frame_done = 1 together with o_win_valid for the pixel at (IMG_W-1, IMG_H-1).
- Back-to-back: with i_valid held at 1, one window per cycle is produced in the interior. With gaps, windows follow the accepted pixels exactly.
- Reset mid-frame:
  - Counters return to (0,0) and o_win_valid drops asynchronously.
  - Stale RAM data never reaches a valid window, because lines 0 and 1 are rewritten before y >= 2.
- Arithmetic: pixels pass through unmodified; the block performs no arithmetic on pixel data.

Test Plan:
- Basic window: IMG_W = 4, IMG_H = 4, pixel(x,y) = {8'(y), 8'(x), 8'hAA}, streamed back-to-back. Required response:
  - The first o_win_valid occurs the cycle after pixel (2,2).
  - p1 = 0x0000AA, p5 = 0x0101AA, p9 = 0x0202AA, o_cx = 1, o_cy = 1.
  - Exactly 4 windows are produced, and o_frame_done accompanies the window with p9 = 0x0303AA.
- Gapped stream: same frame with i_valid randomly 50% low. Required response: identical sequence of 4 windows with identical contents; o_win_valid is never high in a cycle that does not follow an accept.
- Two frames back-to-back: the second frame has different data and i_sof on its first pixel. Required response:
  - No window is produced for pixels (0..3, 0..1) of frame 2.
  - The first window of frame 2 has p1 = frame-2 pixel (0,0).
- SOF resync: assert i_sof at true position (2,1) of frame 1. Required response:
  - The counters restart, so that pixel becomes (0,0) and the next pixel is (1,0).
  - The next window appears after the 11th pixel of the new frame, i.e. at (2,2).
- Reset mid-frame: assert iRst_n low during the second line of a frame. Required response:
  - All outputs read 0 immediately.
  - After release, a full frame produces 4 correct windows with no stale data.
- Full-size frame: default 640x480 frame, continuous. Required response: 638*478 = 304964 windows and exactly one o_frame_done, whose window has o_cx = 638 and o_cy = 478.
